theta_step_unit: RTL and testbench

Sequential Keccak-f[1600] theta step placed directly upstream of the rotate (rho) stage in the encoder permutation chain. Accepts one 1600-bit page over a valid/ready handshake, computes column parities serially over five cycles, applies the theta mix column-by-column over five more cycles, and presents the result for the rotate stage to consume. It holds one page at a time. Back-pressure from the rotate stage holds the page stable.

---
 rtl/theta_pkg.sv | 28 ++
 rtl/theta_d_calc.sv | 26 ++
 rtl/theta_step_unit.sv | 124 ++++++++++++
 tb/tb_theta_step_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/theta_pkg.sv
// rtl/theta_pkg.sv - shared types, geometry constants and index helpers for the theta step
package theta_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARITY = 2'd1,
        APPLY  = 2'd2,
        DONE   = 2'd3
    } theta_state_t;

    localparam int unsigned LANES_X = 5;
    localparam int unsigned LANES_Y = 5;

    function automatic int unsigned lane_base(input int unsigned x, input int unsigned y,
                                              input int unsigned lane_w);
        return lane_w * (x + LANES_X * y);
    endfunction

    // Column indices wrap explicitly 4 -> 0; a 3-bit counter would otherwise run to 7.
    function automatic logic [2:0] mod5_inc(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] mod5_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd4 : v - 3'd1;
    endfunction

endpackage

// File: rtl/theta_d_calc.sv
// rtl/theta_d_calc.sv - combinational theta D term for one column: C[idx-1] ^ rotl1(C[idx+1])
module theta_d_calc
    import theta_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic [LANES_X*LANE_W-1:0] c,
    input  logic [2:0]                idx,
    output logic [LANE_W-1:0]         d
);

    logic [LANE_W-1:0] c_prev;
    logic [LANE_W-1:0] c_next;

    always_comb begin
        c_prev = '0;
        c_next = '0;
        for (int x = 0; x < int'(LANES_X); x++) begin
            if (3'(x) == mod5_dec(idx)) c_prev = c[x*LANE_W +: LANE_W];
            if (3'(x) == mod5_inc(idx)) c_next = c[x*LANE_W +: LANE_W];
        end
    end

    assign d = c_prev ^ {c_next[LANE_W-2:0], c_next[LANE_W-1]};

endmodule

// File: rtl/theta_step_unit.sv
// rtl/theta_step_unit.sv - serial Keccak theta step; THETA_PAGE_CNT_EN adds the page_count output
module theta_step_unit
    import theta_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [25*LANE_W-1:0]  page_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [25*LANE_W-1:0]  page_out,
    output logic                  busy
`ifdef THETA_PAGE_CNT_EN
    ,
    output logic [15:0]           page_count
`endif
);

    localparam int PAGE_W = 25 * LANE_W;

    theta_state_t              state;
    logic [2:0]                idx;
    logic [PAGE_W-1:0]         page_q;
    logic [LANES_X*LANE_W-1:0] c_q;
    logic [LANE_W-1:0]         col_par;
    logic [LANE_W-1:0]         d;
    logic [PAGE_W-1:0]         page_mix;

    always_comb begin
        col_par = '0;
        for (int x = 0; x < int'(LANES_X); x++) begin
            for (int y = 0; y < int'(LANES_Y); y++) begin
                if (3'(x) == idx) col_par = col_par ^ page_q[lane_base(x, y, LANE_W) +: LANE_W];
            end
        end
    end

    theta_d_calc #(.LANE_W(LANE_W)) u_d_calc (
        .c   (c_q),
        .idx (idx),
        .d   (d)
    );

    always_comb begin
        page_mix = page_q;
        for (int x = 0; x < int'(LANES_X); x++) begin
            for (int y = 0; y < int'(LANES_Y); y++) begin
                if (3'(x) == idx) page_mix[lane_base(x, y, LANE_W) +: LANE_W] =
                    page_q[lane_base(x, y, LANE_W) +: LANE_W] ^ d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            page_q    <= '0;
            c_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        page_q   <= page_in;
                        c_q      <= '0;
                        idx      <= 3'd0;
                        state    <= PARITY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                PARITY: begin
                    for (int x = 0; x < int'(LANES_X); x++) begin
                        if (3'(x) == idx) c_q[x*LANE_W +: LANE_W] <= col_par;
                    end
                    if (idx == 3'd4) begin
                        idx   <= 3'd0;
                        state <= APPLY;
                    end else begin
                        idx <= mod5_inc(idx);
                    end
                end
                APPLY: begin
                    page_q <= page_mix;
                    if (idx == 3'd4) begin
                        idx       <= 3'd0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= mod5_inc(idx);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign page_out = page_q;

`ifdef THETA_PAGE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_count <= 16'd0;
        end else if (state == DONE && out_ready) begin
            page_count <= page_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_theta_step_unit.sv
// tb/tb_theta_step_unit.sv - directed bench with a whole-page theta model and per-cycle output compare
module tb_theta_step_unit;

    localparam int LW = 64;
    localparam int PW = 25 * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] page_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] page_out;
    logic          busy;
`ifdef THETA_PAGE_CNT_EN
    logic [15:0]   page_count;
    int            exp_count = 0;
`endif

    int            checks   = 0;
    int            failures = 0;
    logic [PW-1:0] exp_page = '0;

    theta_step_unit #(.LANE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .page_in   (page_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .page_out  (page_out),
        .busy      (busy)
`ifdef THETA_PAGE_CNT_EN
        ,
        .page_count(page_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference theta over the whole page at once, straight from the textbook definition.
    function automatic logic [PW-1:0] theta_model(input logic [PW-1:0] a);
        logic [LW-1:0] c [5];
        logic [LW-1:0] d [5];
        logic [PW-1:0] r;
        r = a;
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[LW*(x+5*y) +: LW];
        end
        for (int x = 0; x < 5; x++)
            d[x] = c[(x+4)%5] ^ {c[(x+1)%5][LW-2:0], c[(x+1)%5][LW-1]};
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[LW*(x+5*y) +: LW] = a[LW*(x+5*y) +: LW] ^ d[x];
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_page();
        logic [PW-1:0] p;
        for (int i = 0; i < PW/32; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_page(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < 25; i++) begin
                if (act[LW*i +: LW] !== exp[LW*i +: LW]) begin
                    $display("FAIL %s lane %0d: got %h expected %h", name, i,
                             act[LW*i +: LW], exp[LW*i +: LW]);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) check_page("page_out_vs_model", page_out, exp_page);
    end

    task automatic accept(input logic [PW-1:0] p);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check1("in_ready_before_accept", 64'(in_ready), 64'd1);
        page_in  = p;
        in_valid = 1'b1;
        exp_page = theta_model(p);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_to_done();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check1("busy_in_flight", 64'(busy), 64'd1);
            check1("in_ready_in_flight", 64'(in_ready), 64'd0);
            check1("out_valid_latency", 64'(out_valid), (k == 10) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1("out_valid_after_hs", 64'(out_valid), 64'd0);
        check1("in_ready_after_hs", 64'(in_ready), 64'd1);
        check1("busy_after_hs", 64'(busy), 64'd0);
`ifdef THETA_PAGE_CNT_EN
        exp_count++;
        check1("page_count", 64'(page_count), 64'(exp_count & 16'hffff));
`endif
    endtask

    initial begin
        logic [PW-1:0] lit;
        logic [PW-1:0] held;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; page_in = '0;
        #12;
        check1("reset_in_ready", 64'(in_ready), 64'd1);
        check1("reset_out_valid", 64'(out_valid), 64'd0);
        check1("reset_busy", 64'(busy), 64'd0);
        check_page("reset_page_out", page_out, '0);
`ifdef THETA_PAGE_CNT_EN
        check1("reset_page_count", 64'(page_count), 64'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        accept('0);
        run_to_done();
        check_page("zero_page", page_out, '0);
        handshake();

        lit = '0;
        lit[LW*0 +: LW] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            lit[LW*(1+5*y) +: LW] = 64'h1;
            lit[LW*(4+5*y) +: LW] = 64'h2;
        end
        lit[LW*1 +: LW] = 64'h1;
        accept(PW'(64'h1));
        run_to_done();
        check_page("single_bit", page_out, lit);
        handshake();

        page_in = '0;
        lit = '0;
        lit[LW*2 +: LW] = 64'h8000_0000_0000_0000;
        held = lit;
        for (int y = 0; y < 5; y++) begin
            lit[LW*(3+5*y) +: LW] = 64'h8000_0000_0000_0000;
            lit[LW*(1+5*y) +: LW] = 64'h1;
        end
        accept(held);
        run_to_done();
        check_page("rotl_wrap", page_out, lit);
        handshake();

        accept(rand_page());
        run_to_done();
        held = page_out;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3 == 0);
            page_in  = rand_page();
            @(posedge clk); #1;
            check1("bp_in_ready", 64'(in_ready), 64'd0);
            check1("bp_out_valid", 64'(out_valid), 64'd1);
            check_page("bp_stable", page_out, held);
        end
        in_valid = 1'b0;
        handshake();

        accept(rand_page());
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check1("midrst_out_valid", 64'(out_valid), 64'd0);
        check1("midrst_busy", 64'(busy), 64'd0);
        check1("midrst_in_ready", 64'(in_ready), 64'd1);
        check_page("midrst_page_out", page_out, '0);
`ifdef THETA_PAGE_CNT_EN
        exp_count = 0;
        check1("midrst_page_count", 64'(page_count), 64'd0);
`endif
        #5;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 4; n++) begin
            accept(rand_page());
            run_to_done();
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
